// File: rtl/pkt_concentrator.sv
// pkt_concentrator: packs parser bytes into LANES-byte words tagged sop/commit/abort.
// Define PKT_CONC_STATS_EN to build the pkt_cnt / err_cnt statistics counters.
module pkt_concentrator #(
  parameter int LANES   = 8,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518,
  parameter int LEN_W   = 14,
  parameter int NB_W    = $clog2(LANES) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 c_srdy,
  output logic                 c_drdy,
  input  logic [1:0]           c_code,
  input  logic [7:0]           c_data,
  output logic                 p_srdy,
  input  logic                 p_drdy,
  output logic [8*LANES-1:0]   p_data,
  output logic [NB_W-1:0]      p_nbytes,
  output logic                 p_sop,
  output logic                 p_commit,
  output logic                 p_abort,
  output logic [15:0]          pkt_cnt,
  output logic [15:0]          err_cnt
);

  localparam int LW = $clog2(LANES);
  localparam int DW = 8 * LANES;
  localparam logic [1:0] C_DATA = 2'b00;
  localparam logic [1:0] C_SOP  = 2'b01;
  localparam logic [1:0] C_EOP  = 2'b10;
  localparam logic [1:0] C_BAD  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DISC
  } state_t;

  state_t           state, state_n;
  logic [DW-1:0]    acc, acc_n, acc_app, byte_w, w_data;
  logic [LW-1:0]    lane, lane_n;
  logic [LEN_W-1:0] len, len_n, len_inc;
  logic             sopp, sopp_n;
  logic [NB_W-1:0]  w_nb;
  logic             w_commit, w_abort, close, stray;
  logic             need_close, ld_ok, fire, giant, full, runt;

  assign ld_ok   = !p_srdy || p_drdy;
  assign c_drdy  = !(need_close && !ld_ok);
  assign fire    = c_srdy && c_drdy;
  assign byte_w  = DW'(c_data);
  assign acc_app = acc | (byte_w << {lane, 3'b000});
  assign len_inc = (len > LEN_W'(MAX_LEN)) ? len : len + LEN_W'(1);
  assign giant   = len_inc > LEN_W'(MAX_LEN);
  assign runt    = len_inc < LEN_W'(MIN_LEN);
  assign full    = lane == LW'(LANES - 1);

  // Would the byte on c_code close a word if accepted this cycle
  always_comb begin
    need_close = 1'b0;
    if (state == S_ACCUM) begin
      if (c_code == C_DATA) need_close = giant || full;
      else                  need_close = 1'b1;
    end
  end

  // Accumulator next state and the word handed to the output register
  always_comb begin
    state_n  = state;
    acc_n    = acc;
    lane_n   = lane;
    len_n    = len;
    sopp_n   = sopp;
    close    = 1'b0;
    stray    = 1'b0;
    w_data   = acc_app;
    w_nb     = NB_W'(lane) + NB_W'(1);
    w_commit = 1'b0;
    w_abort  = 1'b0;
    if (fire) begin
      unique case (state)
        S_IDLE: begin
          if (c_code == C_SOP) begin
            acc_n   = byte_w;
            lane_n  = LW'(1);
            len_n   = LEN_W'(1);
            sopp_n  = 1'b1;
            state_n = S_ACCUM;
          end else begin
            stray = 1'b1;
          end
        end
        S_ACCUM: begin
          close  = need_close;
          acc_n  = acc_app;
          lane_n = lane + LW'(1);
          len_n  = len_inc;
          if (need_close) begin
            acc_n  = '0;
            lane_n = '0;
            sopp_n = 1'b0;
          end
          unique case (c_code)
            C_DATA: begin
              if (giant) begin
                w_abort = 1'b1;
                state_n = S_DISC;
              end
            end
            C_EOP: begin
              w_commit = !giant && !runt;
              w_abort  = giant || runt;
              state_n  = S_IDLE;
            end
            C_BAD: begin
              w_abort = 1'b1;
              state_n = S_IDLE;
            end
            C_SOP: begin
              w_data  = acc;
              w_nb    = NB_W'(lane);
              w_abort = 1'b1;
              acc_n   = byte_w;
              lane_n  = LW'(1);
              len_n   = LEN_W'(1);
              sopp_n  = 1'b1;
            end
          endcase
        end
        S_DISC: begin
          if (c_code == C_SOP) begin
            acc_n   = byte_w;
            lane_n  = LW'(1);
            len_n   = LEN_W'(1);
            sopp_n  = 1'b1;
            state_n = S_ACCUM;
          end else if (c_code != C_DATA) begin
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  // Accumulator and FSM registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      acc   <= '0;
      lane  <= '0;
      len   <= '0;
      sopp  <= 1'b0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      lane  <= lane_n;
      len   <= len_n;
      sopp  <= sopp_n;
    end
  end

  // One-word output register, reloads while draining
  always_ff @(posedge clk) begin
    if (reset) begin
      p_srdy   <= 1'b0;
      p_data   <= '0;
      p_nbytes <= '0;
      p_sop    <= 1'b0;
      p_commit <= 1'b0;
      p_abort  <= 1'b0;
    end else if (close) begin
      p_srdy   <= 1'b1;
      p_data   <= w_data;
      p_nbytes <= w_nb;
      p_sop    <= sopp;
      p_commit <= w_commit;
      p_abort  <= w_abort;
    end else if (p_drdy) begin
      p_srdy   <= 1'b0;
    end
  end

`ifdef PKT_CONC_STATS_EN
  logic [15:0] pkt_q, err_q;

  // Committed-packet and error statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_q <= '0;
      err_q <= '0;
    end else begin
      if (close && w_commit)           pkt_q <= pkt_q + 16'd1;
      if ((close && w_abort) || stray) err_q <= err_q + 16'd1;
    end
  end

  assign pkt_cnt = pkt_q;
  assign err_cnt = err_q;
`else
  logic unused_stats;
  assign unused_stats = stray ^ w_commit;
  assign pkt_cnt = '0;
  assign err_cnt = '0;
`endif

endmodule

// File: doc/pkt_concentrator.md
# pkt_concentrator

Parametrised successor to the bridge's receive concentrator. It sits between the packet parser's byte stream and the receive packet FIFO. It packs 8-bit coded bytes into LANES-byte words and marks each word with a start-of-packet flag and a valid byte count. It enforces minimum and maximum frame lengths and recovers from framing errors. It closes every packet with commit or abort, so the downstream sd_fifo_b keeps or discards the whole frame.

## Interface
- LANES, 8, bytes per output word; power of two, 2..16
- MIN_LEN, 64, shortest good frame in bytes
- MAX_LEN, 1518, longest good frame in bytes
- LEN_W, 14, byte-counter width; 2**LEN_W > MAX_LEN+1
- NB_W, clog2(LANES)+1, width of p_nbytes
- clk  input  1  block clock
- reset  input  1  synchronous, active-high
- c_srdy  input  1  consumer-side byte valid
- c_drdy  output  1  consumer-side byte accept
- c_code  input  2  byte code: 00 DATA, 01 SOP, 10 EOP, 11 BADEOP
- c_data  input  8  byte
- p_srdy  output  1  output word valid
- p_drdy  input  1  output word accept
- p_data  output  8*LANES  packed bytes; first byte in [7:0]; unused lanes zero
- p_nbytes  output  NB_W  valid bytes in word, 0..LANES
- p_sop  output  1  first word of packet
- p_commit  output  1  last word of good packet
- p_abort  output  1  last word of bad packet
- pkt_cnt  output  16  committed packets (stats)
- err_cnt  output  16  aborted packets plus stray bytes (stats)

## Operation
- Datapath: byte accumulator (lane index, byte counter len, sop_pending) feeding a one-word output register.
- States:
  - IDLE: accept all bytes. SOP loads lane 0, sets len=1 and sop_pending, and moves to ACCUM. DATA/EOP/BADEOP are stray: dropped, err_cnt+1.
  - ACCUM:
    - DATA: append the byte and increment len. A full accumulator (LANES bytes) transfers to the output register.
    - EOP: append and close the word. If len < MIN_LEN the word carries p_abort, otherwise p_commit. Go to IDLE.
    - BADEOP: append, close with p_abort, go to IDLE.
    - SOP: close the current partial word with p_abort; this word may be empty (nbytes=0). The SOP byte is held (c_drdy=0) until that word has moved to the output register, then starts a new packet.
  - Giant: when len would exceed MAX_LEN, the offending byte is appended and the word is closed with p_abort. Go to DISCARD.
  - DISCARD: accept and drop bytes until EOP/BADEOP (dropped, go to IDLE) or SOP (starts a new packet, go to ACCUM). No words are emitted.
- The last word of every packet asserts exactly one of p_commit or p_abort. No other word asserts either.
- p_sop is set on the first word emitted after SOP. A one-word packet carries p_sop together with commit or abort.
- len saturates at MAX_LEN+1; there is no wrap.
- Output register transfer: the register loads when it is empty or when it is draining this cycle (p_srdy & p_drdy).
- c_drdy=0 only when the accepted byte would close a word (or a held SOP must close one) while the output register is full and not draining.
- Counters wrap at 16 bits.
  - pkt_cnt increments on transfer of a commit word.
  - err_cnt increments on transfer of an abort word, and on each stray byte.

## Timing
- Reset values:
  - c_drdy=1
  - p_srdy=0, p_data=0, p_nbytes=0
  - p_sop=0, p_commit=0, p_abort=0
  - counters 0
  - state IDLE
- Latency: p_srdy rises the cycle after the byte that closes a word is accepted.
- Throughput: one byte per cycle sustained while p_drdy is high.
- p_data, p_nbytes, p_sop, p_commit and p_abort are stable while p_srdy=1 and p_drdy=0.
- Reset mid-packet: the accumulator and output word are discarded with no abort emitted. Subsequent non-SOP bytes count as stray.

## Configuration
- PKT_CONC_STATS_EN defined: pkt_cnt and err_cnt are implemented as above.
- Not defined: no counter flops; pkt_cnt and err_cnt are tied to 0.
- Datapath behaviour is identical with or without the macro.

## Test plan
- LANES=8, 64-byte good frame, p_drdy=1:
  - 8 words, all nbytes=8
  - word 1 p_sop, word 8 p_commit
  - pkt_cnt=1, c_drdy never low
- 65-byte frame: 9 words; word 9 has nbytes=1, p_commit, and p_data[63:8]=0.
- 60-byte runt ending in EOP: 8 words; word 8 has nbytes=4 and p_abort; err_cnt=1, pkt_cnt=0.
- 1600-byte giant:
  - word 190 has nbytes=7 and p_abort (byte 1519)
  - remaining bytes through EOP are dropped; next 64-byte frame commits normally
- SOP arrives after 10 bytes with p_drdy=0:
  - word 2 (nbytes=2, p_abort) is held and c_drdy stays low
  - after p_drdy rises, the new packet's first word shows p_sop
- Stray DATA×3 in IDLE: no p_srdy, err_cnt=3. Repeat with p_drdy randomly toggled: output sequence identical and no word lost or duplicated.
